// File: rtl/sysid_rom_arbiter.sv
// Two-requester arbiter for a shared synchronous system-ID ROM. One access is in flight at a time.
// Define SYSID_ARB_RR_EN to break ties round-robin; otherwise requester 0 has fixed priority.
module sysid_rom_arbiter #(
  parameter int ROM_WIDTH     = 32,
  parameter int ROM_ADDR_BITS = 6,
  parameter int ROM_DEPTH     = 64,
  parameter int ROM_LATENCY   = 1
) (
  input  logic                     up_clk,
  input  logic                     up_rst,
  input  logic                     req0_valid,
  input  logic [ROM_ADDR_BITS-1:0] req0_addr,
  output logic                     req0_ack,
  output logic [ROM_WIDTH-1:0]     req0_data,
  input  logic                     req1_valid,
  input  logic [ROM_ADDR_BITS-1:0] req1_addr,
  output logic                     req1_ack,
  output logic [ROM_WIDTH-1:0]     req1_data,
  output logic                     rom_en,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]     rom_data,
  output logic                     busy,
  output logic                     grant
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_e;

  state_e                   state_q;
  logic [1:0]               lat_cnt_q;
  logic                     oor_q;
  logic                     grant_q;
  logic                     busy_q;
  logic                     rom_en_q;
  logic                     ack0_q;
  logic                     ack1_q;
  logic [ROM_ADDR_BITS-1:0] rom_addr_q;
  logic [ROM_WIDTH-1:0]     data0_q;
  logic [ROM_WIDTH-1:0]     data1_q;

  logic                     win_d;
  logic [ROM_ADDR_BITS-1:0] sel_addr_d;
  logic                     oor_d;

`ifdef SYSID_ARB_RR_EN
  logic last_grant_q;
  // On a tie the requester that did not win last time goes next.
  assign win_d = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
`else
  assign win_d = ~req0_valid;
`endif

  assign sel_addr_d = win_d ? req1_addr : req0_addr;
  assign oor_d      = {{(32-ROM_ADDR_BITS){1'b0}}, sel_addr_d} >= 32'(ROM_DEPTH);

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= '0;
      oor_q      <= 1'b0;
      grant_q    <= 1'b0;
      busy_q     <= 1'b0;
      rom_en_q   <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rom_addr_q <= '0;
      data0_q    <= '0;
      data1_q    <= '0;
`ifdef SYSID_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req0_valid || req1_valid) begin
            grant_q    <= win_d;
            rom_addr_q <= sel_addr_d;
            oor_q      <= oor_d;
            rom_en_q   <= ~oor_d;
            busy_q     <= 1'b1;
            state_q    <= S_ISSUE;
`ifdef SYSID_ARB_RR_EN
            last_grant_q <= win_d;
`endif
          end
        end
        S_ISSUE: begin
          rom_en_q  <= 1'b0;
          lat_cnt_q <= 2'(ROM_LATENCY - 1);
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt_q == 2'd0) begin
            // Out-of-range accesses never enabled the ROM, so return zero on the same schedule.
            if (grant_q) begin
              data1_q <= oor_q ? '0 : rom_data;
              ack1_q  <= 1'b1;
            end else begin
              data0_q <= oor_q ? '0 : rom_data;
              ack0_q  <= 1'b1;
            end
            state_q <= S_ACK;
          end else begin
            lat_cnt_q <= lat_cnt_q - 2'd1;
          end
        end
        S_ACK: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req0_ack  = ack0_q;
  assign req1_ack  = ack1_q;
  assign req0_data = data0_q;
  assign req1_data = data1_q;
  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_sysid_rom_arbiter.sv
// Bench for sysid_rom_arbiter: a transaction-schedule model predicts every output each cycle,
// while directed and randomized requester traffic exercises latency, range, arbitration and reset.
module tb_sysid_rom_arbiter;

  localparam int L     = 3;
  localparam int DEPTH = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [5:0]  a0 = '0, a1 = '0;
  logic        ack0, ack1, rom_en, busy, grant;
  logic [31:0] d0, d1, rom_data;
  logic [5:0]  rom_addr;

  sysid_rom_arbiter #(
    .ROM_WIDTH(32), .ROM_ADDR_BITS(6), .ROM_DEPTH(DEPTH), .ROM_LATENCY(L)
  ) dut (
    .up_clk(clk), .up_rst(rst),
    .req0_valid(v0), .req0_addr(a0), .req0_ack(ack0), .req0_data(d0),
    .req1_valid(v1), .req1_addr(a1), .req1_ack(ack1), .req1_data(d1),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  // ROM: data appears L cycles after an enable; other cycles deliver garbage.
  logic [31:0] mem [64];
  logic [31:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= rom_en ? mem[rom_addr] : $urandom;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign rom_data = pipe[L-1];

  int passes = 0;
  int total  = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: each grant at cycle c schedules issue at s=c+1, ack at s+L+1, next idle at s+L+2.
  int          cyc = 0, m_s = 0;
  bit          m_active = 0, m_oor = 0, m_w = 0, m_grant = 0;
  logic [5:0]  m_addr = '0, m_raddr = '0;
  logic [31:0] m_d0 = '0, m_d1 = '0;
  bit          e_busy = 0, e_en = 0, e_ack0 = 0, e_ack1 = 0;
`ifdef SYSID_ARB_RR_EN
  bit          m_last = 1;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_grant = 0; m_raddr = '0; m_d0 = '0; m_d1 = '0;
      cyc = 0; m_s = 0;
      e_busy = 0; e_en = 0; e_ack0 = 0; e_ack1 = 0;
`ifdef SYSID_ARB_RR_EN
      m_last = 1;
`endif
    end else begin
      if ((!m_active || cyc >= m_s + L + 2) && (v0 || v1)) begin
        if (v0 && v1) begin
`ifdef SYSID_ARB_RR_EN
          m_w = !m_last;
          m_last = m_w;
`else
          m_w = 0;
`endif
        end else begin
          m_w = v1;
`ifdef SYSID_ARB_RR_EN
          m_last = m_w;
`endif
        end
        m_addr   = m_w ? a1 : a0;
        m_oor    = (int'(m_addr) >= DEPTH);
        m_s      = cyc + 1;
        m_active = 1;
        m_grant  = m_w;
        m_raddr  = m_addr;
      end
      cyc++;
      e_busy = m_active && cyc >= m_s && cyc <= m_s + L + 1;
      e_en   = m_active && cyc == m_s && !m_oor;
      e_ack0 = m_active && cyc == m_s + L + 1 && !m_w;
      e_ack1 = m_active && cyc == m_s + L + 1 && m_w;
      if (e_ack0) m_d0 = m_oor ? 32'h0 : mem[m_addr];
      if (e_ack1) m_d1 = m_oor ? 32'h0 : mem[m_addr];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, e_busy});
      chk("rom_en", {31'b0, rom_en}, {31'b0, e_en});
      chk("rom_addr", {26'b0, rom_addr}, {26'b0, m_raddr});
      chk("grant", {31'b0, grant}, {31'b0, m_grant});
      chk("req0_ack", {31'b0, ack0}, {31'b0, e_ack0});
      chk("req1_ack", {31'b0, ack1}, {31'b0, e_ack1});
      chk("req0_data", d0, m_d0);
      chk("req1_data", d1, m_d1);
    end
  end

  task automatic set_req(input int idx, input bit v, input logic [5:0] a);
    if (idx == 0) begin v0 = v; a0 = a; end
    else          begin v1 = v; a1 = a; end
  endtask

  function automatic bit ack_of(input int idx);
    return (idx == 0) ? ack0 : ack1;
  endfunction

  function automatic logic [31:0] data_of(input int idx);
    return (idx == 0) ? d0 : d1;
  endfunction

  // Single isolated access with literal latency expectations.
  task automatic do_one(input int idx, input logic [5:0] addr, input logic [31:0] exp_data,
                        input bit exp_en);
    int n_en, n_ack;
    n_en = -1; n_ack = -1;
    @(negedge clk); #1;
    set_req(idx, 1'b1, addr);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rom_en && n_en < 0) n_en = n;
      if (ack_of(idx)) begin n_ack = n; break; end
    end
    chk("dir_ack_latency", 32'(n_ack), 32'(L + 2));
    chk("dir_en_cycle", 32'(n_en), exp_en ? 32'd1 : 32'hFFFF_FFFF);
    chk("dir_data", data_of(idx), exp_data);
    $display("access req%0d addr %0h: ack cycle %0d, data %0h", idx, addr, n_ack, data_of(idx));
    #1 set_req(idx, 1'b0, addr);
  endtask

  task automatic run_req(input int idx, input int cnt);
    bit got;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      #1 set_req(idx, 1'b1, 6'($urandom_range(0, 63)));
      got = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (ack_of(idx)) begin got = 1; break; end
      end
      chk("rnd_ack_seen", {31'b0, got}, 32'd1);
      $display("random req%0d #%0d: data %0h", idx, i, data_of(idx));
      #1 set_req(idx, 1'b0, idx == 0 ? a0 : a1);
    end
  endtask

  int c0, c1, n_ack;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[5]  = 32'hA5A5_0001;
    mem[47] = 32'h0BAD_F00D;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rom_en", {31'b0, rom_en}, 32'd0);
    chk("rst_grant", {31'b0, grant}, 32'd0);
    chk("rst_data0", d0, 32'd0);
    #1 rst = 0;
    chk_en = 1;

    do_one(0, 6'h05, 32'hA5A5_0001, 1);
    do_one(1, 6'h3F, 32'h0, 0);
    do_one(1, 6'h2F, 32'h0BAD_F00D, 1);
    do_one(0, 6'h30, 32'h0, 0);
    do_one(0, 6'h00, mem[0], 1);

    // Both requesters held; eight access slots.
    c0 = 0; c1 = 0;
    @(negedge clk); #1;
    v0 = 1; a0 = 6'h05; v1 = 1; a1 = 6'h2F;
    for (int n = 1; n <= 8 * (L + 3); n++) begin
      @(negedge clk);
      if (ack0) c0++;
      if (ack1) c1++;
    end
    #1 v0 = 0; v1 = 0;
    $display("held tie: req0 acks %0d, req1 acks %0d", c0, c1);
`ifdef SYSID_ARB_RR_EN
    chk("rr_acks0", 32'(c0), 32'd4);
    chk("rr_acks1", 32'(c1), 32'd4);
`else
    chk("fixed_acks0", 32'(c0), 32'd8);
    chk("fixed_acks1", 32'(c1), 32'd0);
`endif
    repeat (L + 4) @(negedge clk);

    // Reset in the middle of a req1 wait; the held request must then complete.
    #1 v1 = 1; a1 = 6'd20;
    repeat (2) @(negedge clk);
    #1 rst = 1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_ack1", {31'b0, ack1}, 32'd0);
    chk("mid_rst_rom_en", {31'b0, rom_en}, 32'd0);
    chk("mid_rst_data1", d1, 32'd0);
    @(negedge clk); #1 rst = 0;
    n_ack = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack1) begin n_ack = n; break; end
    end
    chk("post_rst_latency", 32'(n_ack), 32'(L + 2));
    chk("post_rst_data", d1, mem[20]);
    $display("post-reset req1 addr 14: ack cycle %0d, data %0h", n_ack, d1);
    #1 v1 = 0;

    fork
      run_req(0, 25);
      run_req(1, 25);
    join
    repeat (L + 4) @(negedge clk);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
